// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern sequencer: FSM encoding and the legacy reset pattern.
package pattern_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Entry 0 sits in the LSBs: AF BC E2 78 FF E2 0B 8D
  localparam logic [63:0] LEGACY_PATTERN = 64'h8D0BE2FF78E2BCAF;

endpackage

// File: rtl/pattern_table.sv
// DEPTH x DATA_W register file with one write port and one combinational read port.
module pattern_table #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] INIT_PATTERN = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Out-of-range addresses only exist for non-power-of-2 depths; drop those writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_PATTERN[i*DATA_W +: DATA_W];
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pattern_sequencer.sv
// Replays a writable pattern table on a valid/ready stream, one-shot or looping, with start/stop.
// state   | meaning
// ST_IDLE | no sequence active, out_valid low, waiting for start
// ST_RUN  | presenting beats, advancing idx on each transfer
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] INIT_PATTERN = LEGACY_PATTERN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [ADDR_W:0]   seq_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_t        state;
  logic [ADDR_W-1:0] idx, idx_next, rd_addr;
  logic [ADDR_W:0]   len_q, len_start;
  logic              loop_q, stop_pend, xfer, at_end, end_seq;
  logic [DATA_W-1:0] rd_data;

  pattern_table #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .INIT_PATTERN(INIT_PATTERN)
  ) u_table (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // The read port always points at the entry the next load would fetch.
  always_comb begin
    len_start = ((seq_len == '0) || (seq_len > DEPTH_L)) ? DEPTH_L : seq_len;
    xfer      = out_valid && out_ready;
    at_end    = ({1'b0, idx} == len_q - 1'b1);
    idx_next  = at_end ? '0 : idx + 1'b1;
    end_seq   = (at_end && !loop_q) || stop || stop_pend;
    rd_addr   = (state == ST_RUN) ? idx_next : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      stop_pend <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            idx       <= '0;
            len_q     <= len_start;
            loop_q    <= loop_mode;
            stop_pend <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_last  <= (len_start == 1);
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (xfer) begin
            if (end_seq) begin
              state     <= ST_IDLE;
              idx       <= '0;
              stop_pend <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= idx_next;
              out_data <= rd_data;
              out_last <= ({1'b0, idx_next} == len_q - 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with hand-computed expected beats.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       start, stop, loop_mode;
  logic [3:0] seq_len;
  logic       out_valid, out_ready, out_last, busy, done;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] legacy [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  pattern_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stop     (stop),
    .loop_mode(loop_mode),
    .seq_len  (seq_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] exp_data, input logic exp_last);
    chk({tag, " valid"}, 8'(out_valid), 8'h01);
    chk({tag, " data"}, out_data, exp_data);
    chk({tag, " last"}, 8'(out_last), 8'(exp_last));
  endtask

  task automatic chk_ended(input string tag);
    chk({tag, " done"}, 8'(done), 8'h01);
    chk({tag, " valid"}, 8'(out_valid), 8'h00);
    chk({tag, " busy"}, 8'(busy), 8'h00);
  endtask

  task automatic begin_seq(input logic lp, input logic [3:0] len);
    loop_mode = lp;
    seq_len   = len;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_mode = 1'b0; seq_len = 4'd8; out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state, then one-shot legacy sequence
    chk("rst valid", 8'(out_valid), 8'h00);
    chk("rst data", out_data, 8'h00);
    chk("rst last", 8'(out_last), 8'h00);
    chk("rst busy", 8'(busy), 8'h00);
    chk("rst done", 8'(done), 8'h00);
    begin_seq(1'b0, 4'd8);
    chk("t1 busy", 8'(busy), 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("t1 beat%0d", i), legacy[i], i == 7);
      tick();
    end
    chk_ended("t1 end");
    tick();
    chk("t1 done pulse", 8'(done), 8'h00);

    // 2: loop len=3, start+stop together (stop ignored), then stop with same-cycle transfer
    stop = 1'b1;
    begin_seq(1'b1, 4'd3);
    stop = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_beat($sformatf("t2 beat%0d", i), legacy[i % 3], (i % 3) == 2);
      tick();
    end
    chk_beat("t2 beat7", 8'hBC, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_ended("t2 stop");
    tick();

    // 3: stall with ready 1,0,0,1
    begin_seq(1'b0, 4'd4);
    chk_beat("t3 b0", 8'hAF, 1'b0);
    tick();
    chk_beat("t3 b1", 8'hBC, 1'b0);
    out_ready = 1'b0;
    tick();
    chk_beat("t3 stall1", 8'hBC, 1'b0);
    tick();
    chk_beat("t3 stall2", 8'hBC, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_beat("t3 b2", 8'hE2, 1'b0);
    tick();
    chk_beat("t3 b3", 8'h78, 1'b1);
    tick();
    chk_ended("t3 end");
    tick();

    // 4: overwrite the held entry; 5: stop during a stalled beat in loop mode
    begin_seq(1'b1, 4'd3);
    chk_beat("t4 b0", 8'hAF, 1'b0);
    tick();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    chk_beat("t4 held", 8'hBC, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_beat("t4 b2", 8'hE2, 1'b1);
    tick();
    chk_beat("t4 b3", 8'hAF, 1'b0);
    tick();
    chk_beat("t4 new", 8'h55, 1'b0);
    tick();
    chk_beat("t5 b5", 8'hE2, 1'b1);
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_beat("t5 pend", 8'hE2, 1'b1);
    chk("t5 pend busy", 8'(busy), 8'h01);
    chk("t5 pend done", 8'(done), 8'h00);
    out_ready = 1'b1;
    tick();
    chk_ended("t5 end");
    tick();
    chk("t5 no beat4", 8'(out_valid), 8'h00);

    // 6: async reset mid-run restores table; len=0 clamps to full depth
    begin_seq(1'b1, 4'd8);
    tick();
    tick();
    chk_beat("t6 pre", 8'hE2, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6 rst valid", 8'(out_valid), 8'h00);
    chk("t6 rst data", out_data, 8'h00);
    chk("t6 rst busy", 8'(busy), 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    begin_seq(1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("t6 beat%0d", i), legacy[i], i == 7);
      tick();
    end
    chk_ended("t6 end");

    // start in the done cycle is honoured
    seq_len = 4'd2;
    loop_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t7 b0", 8'hAF, 1'b0);
    tick();
    chk_beat("t7 b1", 8'hBC, 1'b1);
    tick();
    chk_ended("t7 end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
